// File: rtl/lut_cfg_pkg.sv
// Shared constants and state encoding for the soft-LUT configuration path.
// Used by the sequencer, the LUT column and the CLB top.
package lut_cfg_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StCommit = 2'd2,
    StDone   = 2'd3
  } cfg_state_e;

  localparam int unsigned DefInputs  = 4;
  localparam int unsigned DefWordW   = 8;
  localparam int unsigned DefNumLuts = 4;

  // Image bits per fracturable LUT: two truth tables plus the use_fracture flag.
  function automatic int unsigned cfg_w(input int unsigned inputs);
    return 2 * (32'd1 << inputs) + 1;
  endfunction

  function automatic int unsigned words_per_lut(input int unsigned cfg_width,
                                                input int unsigned word_w);
    return (cfg_width + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/cfg_word_assembler.sv
// Word counter plus image register: drops each accepted word into its lane of the
// image, LSB-first, and flags the final word of a LUT.
module cfg_word_assembler
  import lut_cfg_pkg::*;
#(
  parameter int unsigned CFG_W  = 33,
  parameter int unsigned WORD_W = 8,
  localparam int unsigned WPL   = words_per_lut(CFG_W, WORD_W),
  localparam int unsigned CntW  = $clog2(WPL + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [CFG_W-1:0]  image_o,
  output logic              last_word_o
);

  logic [CntW-1:0]  word_cnt_q, word_cnt_d;
  logic [CFG_W-1:0] image_q, image_d;
  logic [CFG_W-1:0] word_ext, lane_mask;
  logic [31:0]      lane_off;

  always_comb begin
    last_word_o = accept_i && (word_cnt_q == CntW'(WPL - 1));
    // Lanes shifted past CFG_W fall off, which drops the padding bits of the last word.
    word_ext  = CFG_W'(word_i);
    lane_mask = CFG_W'({WORD_W{1'b1}});
    lane_off  = 32'(word_cnt_q) * WORD_W;
  end

  always_comb begin
    word_cnt_d = word_cnt_q;
    image_d    = image_q;
    if (clear_i) begin
      word_cnt_d = '0;
    end else if (accept_i) begin
      word_cnt_d = last_word_o ? '0 : word_cnt_q + CntW'(1);
      image_d    = (image_q & ~(lane_mask << lane_off)) | (word_ext << lane_off);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
      image_q    <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      image_q    <= image_d;
    end
  end

  assign image_o = image_q;

endmodule

// File: rtl/lut_cfg_sequencer.sv
// Streams LUT images from a valid/ready config port onto the shared config bus and
// strobes each LUT's comb_set in index order; done pulses after the last LUT.
module lut_cfg_sequencer
  import lut_cfg_pkg::*;
#(
  parameter int unsigned INPUTS   = DefInputs,
  parameter int unsigned NUM_LUTS = DefNumLuts,
  parameter int unsigned WORD_W   = DefWordW,
  localparam int unsigned CFG_W   = cfg_w(INPUTS),
  localparam int unsigned IdxW    = $clog2(NUM_LUTS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic                cfg_abort,
  input  logic [WORD_W-1:0]   cfg_word,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [CFG_W-1:0]    config_out,
  output logic [NUM_LUTS-1:0] comb_set,
  output logic                busy,
  output logic                done
);

  cfg_state_e      state_q, state_d;
  logic [IdxW-1:0] lut_idx_q, lut_idx_d;
  logic            accept, clear, last_word;

  always_comb begin
    cfg_ready = (state_q == StLoad);
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    // A word offered in the same cycle as an abort is not consumed.
    accept    = cfg_ready && cfg_valid && !cfg_abort;
  end

  cfg_word_assembler #(
    .CFG_W  (CFG_W),
    .WORD_W (WORD_W)
  ) u_assembler (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (clear),
    .accept_i    (accept),
    .word_i      (cfg_word),
    .image_o     (config_out),
    .last_word_o (last_word)
  );

  always_comb begin
    state_d   = state_q;
    lut_idx_d = lut_idx_q;
    clear     = 1'b0;
    comb_set  = '0;
    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          state_d   = StLoad;
          lut_idx_d = '0;
        end
      end
      StLoad: begin
        if (cfg_abort) begin
          state_d   = StIdle;
          lut_idx_d = '0;
          clear     = 1'b1;
        end else if (last_word) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        if (cfg_abort) begin
          state_d   = StIdle;
          lut_idx_d = '0;
          clear     = 1'b1;
        end else begin
          for (int unsigned i = 0; i < NUM_LUTS; i++) begin
            comb_set[i] = (lut_idx_q == IdxW'(i));
          end
          if (lut_idx_q == IdxW'(NUM_LUTS - 1)) begin
            state_d   = StDone;
            lut_idx_d = '0;
          end else begin
            state_d   = StLoad;
            lut_idx_d = lut_idx_q + IdxW'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      lut_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      lut_idx_q <= lut_idx_d;
    end
  end

endmodule

// File: tb/tb_lut_cfg_sequencer.sv
// Self-checking bench for lut_cfg_sequencer with two LUTs: table-driven loads,
// randomized loads against an arithmetic image model, and abort/reset corner cases.
module tb_lut_cfg_sequencer;

  localparam int NL   = 2;
  localparam int WPL  = 5;
  localparam int NW   = NL * WPL;
  localparam int CW   = 33;
  localparam int AccW = WPL * 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_abort = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [7:0]    cfg_word = 8'h00;
  logic          cfg_ready, busy, done;
  logic [CW-1:0] config_out;
  logic [NL-1:0] comb_set;

  int checks = 0;
  int errors = 0;

  lut_cfg_sequencer #(
    .INPUTS   (4),
    .NUM_LUTS (NL),
    .WORD_W   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_start  (cfg_start),
    .cfg_abort  (cfg_abort),
    .cfg_word   (cfg_word),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .config_out (config_out),
    .comb_set   (comb_set),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NL-1:0] cs;
    logic [CW-1:0] img;
    bit            is_done;
    int            cyc;
  } ev_t;

  typedef struct {
    logic [NW*8-1:0] w;     // word k at bits [8k +: 8]
    int              gap;
    bit              spur;
    logic [CW-1:0]   img0;
    logic [CW-1:0]   img1;
    bit              lat;
  } vec_t;

  ev_t        ev_q[$];
  int         hs_cyc[$];
  logic [7:0] hs_w[$];
  logic [7:0] cur_w[NW];
  vec_t       vecs[3];
  int         cyc = 0;
  int         start_cyc = 0;
  bit         busy_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    ev_q.delete();
    hs_cyc.delete();
    hs_w.delete();
  endtask

  task automatic load_vec(input int i);
    for (int k = 0; k < NW; k++) cur_w[k] = vecs[i].w[k*8 +: 8];
  endtask

  // Image as the plain sum of a LUT's words placed at 8-bit lanes, cut to CW bits.
  function automatic logic [CW-1:0] model_img(input int lut);
    logic [AccW-1:0] acc;
    acc = '0;
    for (int k = 0; k < WPL; k++) acc |= AccW'(cur_w[lut*WPL + k]) << (8 * k);
    return acc[CW-1:0];
  endfunction

  // Observe outputs mid-cycle; handshakes seen here complete at the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      chk("onehot0", 64'($onehot0(comb_set)), 64'd1);
      if (busy && !busy_prev) start_cyc = cyc;
      busy_prev = busy;
      if (cfg_valid && cfg_ready) begin
        hs_cyc.push_back(cyc);
        hs_w.push_back(cfg_word);
      end
      if (comb_set != '0) ev_q.push_back('{cs: comb_set, img: config_out, is_done: 1'b0, cyc: cyc});
      if (done) ev_q.push_back('{cs: '0, img: '0, is_done: 1'b1, cyc: cyc});
    end
  end

  task automatic feed(input int first, input int n, input int gap_mode, input bit spur);
    for (int k = first; k < first + n; k++) begin
      int g;
      int budget;
      g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      cfg_valid = 1'b0;
      repeat (g) begin
        cfg_start = spur;
        cfg_word  = 8'($urandom);
        tick();
      end
      cfg_start = spur;
      cfg_valid = 1'b1;
      cfg_word  = cur_w[k];
      budget = 0;
      while (!cfg_ready && budget < 20) begin
        tick();
        budget++;
      end
      if (budget >= 20) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: got cfg_ready=0 for 20 cycles expected 1 (word %0d)", k);
        cfg_valid = 1'b0;
        cfg_start = 1'b0;
        return;
      end
      tick();
    end
    cfg_valid = 1'b0;
    cfg_start = 1'b0;
  endtask

  task automatic run_load(input int gap_mode, input bit spur);
    int b;
    clear_logs();
    cfg_valid = 1'b1;  // offered while idle; must not be consumed
    cfg_word  = 8'hEE;
    tick();
    cfg_valid = 1'b0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    feed(0, NW, gap_mode, spur);
    b = 0;
    while (!done && b < 40) begin
      tick();
      b++;
    end
    if (b >= 40) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0 for 40 cycles expected 1");
    end
    tick();
    tick();
  endtask

  task automatic check_load(input logic [CW-1:0] img0, input logic [CW-1:0] img1, input bit lat);
    int ok;
    chk("hs_count", 64'(hs_w.size()), 64'(NW));
    ok = 1;
    for (int k = 0; k < hs_w.size() && k < NW; k++) if (hs_w[k] !== cur_w[k]) ok = 0;
    chk("hs_words", 64'(ok), 64'd1);
    chk("ev_count", 64'(ev_q.size()), 64'd3);
    if (ev_q.size() == 3 && hs_cyc.size() == NW) begin
      chk("lut0_strobe", 64'(ev_q[0].cs), 64'b01);
      chk("lut0_image", 64'(ev_q[0].img), 64'(img0));
      chk("lut0_latency", 64'(ev_q[0].cyc), 64'(hs_cyc[WPL-1] + 1));
      chk("lut1_strobe", 64'(ev_q[1].cs), 64'b10);
      chk("lut1_image", 64'(ev_q[1].img), 64'(img1));
      chk("lut1_latency", 64'(ev_q[1].cyc), 64'(hs_cyc[NW-1] + 1));
      chk("done_pulse", 64'(ev_q[2].is_done), 64'd1);
      chk("done_latency", 64'(ev_q[2].cyc), 64'(ev_q[1].cyc + 1));
      if (lat) chk("start_to_done", 64'(ev_q[2].cyc - start_cyc), 64'd12);
    end
  endtask

  initial begin
    vecs[0] = '{w: 80'h0A090807060504030201, gap: 0, spur: 1'b0,
                img0: 33'h1_0403_0201, img1: 33'h0_0908_0706, lat: 1'b1};
    vecs[1] = '{w: 80'h0A090807060504030201, gap: 1, spur: 1'b0,
                img0: 33'h1_0403_0201, img1: 33'h0_0908_0706, lat: 1'b0};
    vecs[2] = '{w: 80'hE5D4C3B2A1FF44332211, gap: 0, spur: 1'b1,
                img0: 33'h1_4433_2211, img1: 33'h1_D4C3_B2A1, lat: 1'b1};

    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(cfg_ready), 64'd0);
    chk("rst_comb_set", 64'(comb_set), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_config_out", 64'(config_out), 64'd0);
    #11 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) begin
      load_vec(i);
      run_load(vecs[i].gap, vecs[i].spur);
      check_load(vecs[i].img0, vecs[i].img1, vecs[i].lat);
    end

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NW; k++) cur_w[k] = 8'($urandom);
      run_load(2, 1'($urandom_range(0, 1)));
      check_load(model_img(0), model_img(1), 1'b0);
    end

    // Abort after three words of LUT1, then a fresh load must begin at LUT0.
    clear_logs();
    load_vec(2);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    feed(0, WPL + 3, 0, 1'b0);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    chk("abort_load_idle", 64'(busy), 64'd0);
    repeat (3) tick();
    chk("abort_load_events", 64'(ev_q.size()), 64'd1);
    if (ev_q.size() >= 1) chk("abort_load_lut0", 64'(ev_q[0].cs), 64'b01);
    load_vec(0);
    run_load(0, 1'b0);
    check_load(vecs[0].img0, vecs[0].img1, 1'b1);

    // Abort landing on LUT1's commit cycle suppresses the strobe.
    clear_logs();
    load_vec(2);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    feed(0, NW, 0, 1'b0);
    cfg_abort = 1'b1;
    #1;
    chk("abort_commit_strobe", 64'(comb_set), 64'd0);
    chk("abort_commit_done", 64'(done), 64'd0);
    tick();
    cfg_abort = 1'b0;
    chk("abort_commit_idle", 64'(busy), 64'd0);
    chk("abort_commit_ready", 64'(cfg_ready), 64'd0);
    repeat (2) tick();
    chk("abort_commit_events", 64'(ev_q.size()), 64'd1);
    load_vec(1);
    run_load(0, 1'b0);
    check_load(vecs[1].img0, vecs[1].img1, 1'b1);

    // Asynchronous reset while a strobe is high.
    clear_logs();
    load_vec(0);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    feed(0, WPL, 0, 1'b0);
    chk("pre_reset_strobe", 64'(comb_set), 64'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_comb_set", 64'(comb_set), 64'd0);
    chk("async_rst_ready", 64'(cfg_ready), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_config_out", 64'(config_out), 64'd0);
    #3 rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 64'(busy), 64'd0);
    load_vec(2);
    run_load(1, 1'b1);
    check_load(vecs[2].img0, vecs[2].img1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test expected finish before 300000");
    $fatal(1);
  end

endmodule
